// File: rtl/adder_pkg.sv
// ============================================================================
// Module : adder_pkg
// Brief  : Shared types and constants for the nibble-serial add sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    localparam int c_SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic sign;
        logic zero;
        logic carry;
        logic parity;
        logic overflow;
    } flags_t;

endpackage

`default_nettype wire

// File: rtl/nibble_add.sv
// ============================================================================
// Module : nibble_add
// Brief  : Single 4-bit add slice with carry in/out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_add
    import adder_pkg::*;
(
    input  logic [c_SLICE_W-1:0] a,
    input  logic [c_SLICE_W-1:0] b,
    input  logic                 cin,
    output logic [c_SLICE_W-1:0] s,
    output logic                 cout
);

    logic [c_SLICE_W:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, b} + {{c_SLICE_W{1'b0}}, cin};
    assign s     = w_sum[c_SLICE_W-1:0];
    assign cout  = w_sum[c_SLICE_W];

endmodule

`default_nettype wire

// File: rtl/adder16_seq_ctrl.sv
// ============================================================================
// Module : adder16_seq_ctrl
// Brief  : Nibble-serial W-bit add sequencer with start/done handshake and
//          sign/zero/carry/parity/overflow flags. Define ADDSEQ_SUB_EN to add
//          the op port (op=1 computes x - y).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adder16_seq_ctrl
    import adder_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef ADDSEQ_SUB_EN
    input  logic         op,
`endif
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] z,
    output logic         sign,
    output logic         zero,
    output logic         carry,
    output logic         parity,
    output logic         overflow
);

    // W must be a multiple of the slice width
    localparam int c_NSLICE = W / c_SLICE_W;
    localparam int c_IDX_W  = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_NSLICE - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_IDX_W-1:0]     r_idx;
    logic                   r_cy;
    logic [W-1:0]           r_a;
    logic [W-1:0]           r_b;
    logic [W-1:0]           r_zsh;
    logic [W-1:0]           r_z;
    flags_t                 r_flags;
    logic                   r_done;

    logic                   w_accept;
    logic                   w_last;
    logic [W-1:0]           w_b_eff;
    logic                   w_cin0;
    logic [c_SLICE_W-1:0]   w_na;
    logic [c_SLICE_W-1:0]   w_nb;
    logic [c_SLICE_W-1:0]   w_s;
    logic                   w_cout;
    logic [W-1:0]           w_z_next;
    flags_t                 w_flags_next;

    // Subtraction folds into the adder as A + ~B + 1
`ifdef ADDSEQ_SUB_EN
    assign w_b_eff = op ? ~y : y;
    assign w_cin0  = op;
`else
    assign w_b_eff = y;
    assign w_cin0  = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_last   = (r_state == ST_RUN) && (r_idx == c_LAST);

    assign w_na = r_a[r_idx*c_SLICE_W +: c_SLICE_W];
    assign w_nb = r_b[r_idx*c_SLICE_W +: c_SLICE_W];

    nibble_add u_slice (
        .a    (w_na),
        .b    (w_nb),
        .cin  (r_cy),
        .s    (w_s),
        .cout (w_cout)
    );

    // Full result as it will look once the final nibble lands
    always_comb begin
        w_z_next = r_zsh;
        w_z_next[r_idx*c_SLICE_W +: c_SLICE_W] = w_s;

        w_flags_next.sign     = w_z_next[W-1];
        w_flags_next.zero     = ~|w_z_next;
        w_flags_next.carry    = w_cout;
        w_flags_next.parity   = ~^w_z_next;
        w_flags_next.overflow = (r_a[W-1] & r_b[W-1] & ~w_z_next[W-1]) |
                                (~r_a[W-1] & ~r_b[W-1] & w_z_next[W-1]);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_cy    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_zsh   <= '0;
            r_z     <= '0;
            r_flags <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a   <= x;
                r_b   <= w_b_eff;
                r_cy  <= w_cin0;
                r_idx <= '0;
            end else if (r_state == ST_RUN) begin
                r_zsh[r_idx*c_SLICE_W +: c_SLICE_W] <= w_s;
                r_cy <= w_cout;
                if (w_last) begin
                    r_idx   <= '0;
                    r_z     <= w_z_next;
                    r_flags <= w_flags_next;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign ready    = (r_state == ST_IDLE);
    assign done     = r_done;
    assign z        = r_z;
    assign sign     = r_flags.sign;
    assign zero     = r_flags.zero;
    assign carry    = r_flags.carry;
    assign parity   = r_flags.parity;
    assign overflow = r_flags.overflow;

endmodule

`default_nettype wire

// File: tb/tb_adder16_seq_ctrl.sv
// ============================================================================
// Module : tb_adder16_seq_ctrl
// Brief  : Self-checking bench for adder16_seq_ctrl against a plain-arithmetic
//          reference model. Define ADDSEQ_SUB_EN to also exercise subtraction.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adder16_seq_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
`ifdef ADDSEQ_SUB_EN
    logic         op = 1'b0;
`endif
    logic         ready, done, sign, zero, carry, parity, overflow;
    logic [W-1:0] z;
    logic [4:0]   obs_f;

    int checks = 0;
    int failures = 0;

    assign obs_f = {sign, zero, carry, parity, overflow};

    adder16_seq_ctrl #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef ADDSEQ_SUB_EN
        .op       (op),
`endif
        .x        (x),
        .y        (y),
        .ready    (ready),
        .done     (done),
        .z        (z),
        .sign     (sign),
        .zero     (zero),
        .carry    (carry),
        .parity   (parity),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference: whole-word arithmetic, flags as {sign,zero,carry,parity,overflow}
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                         output logic [W-1:0] ez, output logic [4:0] ef);
        logic [W-1:0] bb;
        logic [W:0]   s;
        bb = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
        ez = s[W-1:0];
        ef = {ez[W-1], (ez == '0), s[W], ~^ez,
              (a[W-1] & bb[W-1] & ~ez[W-1]) | (~a[W-1] & ~bb[W-1] & ez[W-1])};
    endtask

    // Drives one operation, returns result and cycles from accept edge to done
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                          output logic [W-1:0] oz, output logic [4:0] of,
                          output int lat, output bit to);
        int n;
        to = 0;
        n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) to = 1;
        start = 1'b1;
        x = a;
        y = b;
`ifdef ADDSEQ_SUB_EN
        op = sub;
`endif
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!done) to = 1;
        oz = z;
        of = obs_f;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, done, z, obs_f} !== {1'b1, 1'b0, 16'h0000, 5'b00000}) begin
            failures++;
            $display("FAIL reset: ready=%b done=%b z=%h flags=%b, required 1 0 0000 00000",
                     ready, done, z, obs_f);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] oz, ez;
        logic [4:0]   of, ef;
        int           lat;
        bit           to;
        logic [W-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
        logic [W-1:0] vb [3] = '{16'h4321, 16'h0001, 16'h0001};
        logic [W-1:0] vz [3] = '{16'h5555, 16'h0000, 16'h8000};
        logic [4:0]   vf [3] = '{5'b00010, 5'b01110, 5'b10001};
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, oz, of, lat, to);
            ez = vz[i];
            ef = vf[i];
            checks++;
            if (to || oz !== ez || of !== ef || lat != 5) begin
                failures++;
                $display("FAIL directed %h+%h: z=%h flags=%b lat=%0d to=%0d, required z=%h flags=%b lat=5",
                         va[i], vb[i], oz, of, lat, to, ez, ef);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                failures++;
                $display("FAIL done_pulse: done=%b ready=%b after done, required 0 1", done, ready);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, oz, ez;
        logic [4:0]   of, ef;
        int           lat;
        bit           to, sub;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom);
            b = W'($urandom);
`ifdef ADDSEQ_SUB_EN
            sub = bit'($urandom_range(0, 1));
`else
            sub = 1'b0;
`endif
            model(a, b, sub, ez, ef);
            run_op(a, b, sub, oz, of, lat, to);
            checks++;
            if (to || oz !== ez || of !== ef || lat != 5) begin
                failures++;
                $display("FAIL random %h op%0d %h: z=%h flags=%b lat=%0d, required z=%h flags=%b lat=5",
                         a, sub, b, oz, of, lat, ez, ef);
            end
        end
    endtask

    task automatic test_restart_ignored();
        logic [W-1:0] ez, cz;
        logic [4:0]   ef, cf;
        int           dones;
        model(16'h1111, 16'h2222, 1'b0, ez, ef);
        @(negedge clk);
        start = 1'b1; x = 16'h1111; y = 16'h2222;
`ifdef ADDSEQ_SUB_EN
        op = 1'b0;
`endif
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b1; x = 16'hAAAA; y = 16'h5555;
        @(posedge clk); @(negedge clk);
        x = 16'h0F0F; y = 16'hF0F0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        dones = 0;
        cz = '0;
        cf = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin
                dones++;
                cz = z;
                cf = obs_f;
            end
        end
        checks++;
        if (dones != 1 || cz !== ez || cf !== ef) begin
            failures++;
            $display("FAIL restart_ignored: dones=%0d z=%h flags=%b, required 1 %h %b",
                     dones, cz, cf, ez, ef);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] oz;
        logic [4:0]   of;
        int           lat, dones;
        bit           to;
        run_op(16'h1234, 16'h4321, 1'b0, oz, of, lat, to);
        @(negedge clk);
        start = 1'b1; x = 16'hFFFF; y = 16'hFFFF;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({ready, done, z, obs_f} !== {1'b1, 1'b0, 16'h0000, 5'b00000}) begin
            failures++;
            $display("FAIL reset_mid_run: ready=%b done=%b z=%h flags=%b, required 1 0 0000 00000",
                     ready, done, z, obs_f);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL reset_no_done: dones=%0d, required 0", dones);
        end
        run_op(16'h0001, 16'h0001, 1'b0, oz, of, lat, to);
        checks++;
        if (to || oz !== 16'h0002 || of !== 5'b00000) begin
            failures++;
            $display("FAIL reset_fresh: z=%h flags=%b, required 0002 00000", oz, of);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, ez;
        logic [4:0]   ef;
        int           cyc, n;
        int           at [4];
        int           bad;
        a = W'($urandom);
        b = W'($urandom);
        model(a, b, 1'b0, ez, ef);
        @(negedge clk);
        start = 1'b1; x = a; y = b;
`ifdef ADDSEQ_SUB_EN
        op = 1'b0;
`endif
        n = 0;
        bad = 0;
        for (cyc = 1; cyc <= 24; cyc++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin
                if (n < 4) at[n] = cyc;
                n++;
                if (z !== ez || obs_f !== ef) bad++;
            end
        end
        start = 1'b0;
        checks++;
        if (n != 4 || bad != 0) begin
            failures++;
            $display("FAIL back_to_back: dones=%0d bad_results=%0d, required 4 0", n, bad);
        end else begin
            checks++;
            if (at[0] != 5 || at[1] != 11 || at[2] != 17 || at[3] != 23) begin
                failures++;
                $display("FAIL b2b_spacing: done cycles %0d %0d %0d %0d, required 5 11 17 23",
                         at[0], at[1], at[2], at[3]);
            end
        end
        repeat (8) @(negedge clk);
    endtask

`ifdef ADDSEQ_SUB_EN
    task automatic test_sub();
        logic [W-1:0] oz;
        logic [4:0]   of;
        int           lat;
        bit           to;
        run_op(16'h0005, 16'h0007, 1'b1, oz, of, lat, to);
        checks++;
        if (to || oz !== 16'hFFFE || of !== 5'b10000) begin
            failures++;
            $display("FAIL sub_5_7: z=%h flags=%b, required fffe 10000", oz, of);
        end
        run_op(16'h8000, 16'h0001, 1'b1, oz, of, lat, to);
        checks++;
        if (to || oz !== 16'h7FFF || of !== 5'b00101) begin
            failures++;
            $display("FAIL sub_8000_1: z=%h flags=%b, required 7fff 00101", oz, of);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_restart_ignored();
        test_reset_mid_run();
        test_back_to_back();
`ifdef ADDSEQ_SUB_EN
        test_sub();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
